// File: rtl/pipeline_hazard_control_pkg.sv
// Shared constants for the SiMPLE pipeline controller: opcodes, next-PC select
// encodings, per-stage metadata record and the decode helper that fills it.
package pipeline_hazard_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] CTL_PC_PC4     = 2'd0;
    localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
    localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;

    typedef enum logic [1:0] {
        CTI_NONE   = 2'd0,
        CTI_BRANCH = 2'd1,
        CTI_JAL    = 2'd2,
        CTI_JALR   = 2'd3
    } cti_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writes_rd;
        logic       is_load;
        logic       is_mem;
        cti_t       cti;
    } stage_meta_t;

    localparam stage_meta_t META_EMPTY = '{valid: 1'b0, rd: 5'd0, writes_rd: 1'b0,
                                           is_load: 1'b0, is_mem: 1'b0, cti: CTI_NONE};

    // rd is only kept for writers so store/branch immediate bits never look like a destination
    function automatic stage_meta_t decode_meta(input logic valid, input logic [6:0] opcode,
                                                input logic [4:0] rd);
        stage_meta_t m;
        m = META_EMPTY;
        m.valid = valid;
        case (opcode)
            OPC_LOAD: begin
                m.writes_rd = 1'b1;
                m.is_load   = 1'b1;
                m.is_mem    = 1'b1;
            end
            OPC_STORE:  m.is_mem = 1'b1;
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: m.writes_rd = 1'b1;
            OPC_JAL: begin
                m.writes_rd = 1'b1;
                m.cti       = CTI_JAL;
            end
            OPC_JALR: begin
                m.writes_rd = 1'b1;
                m.cti       = CTI_JALR;
            end
            OPC_BRANCH: m.cti = CTI_BRANCH;
            default:    m.cti = CTI_NONE;
        endcase
        m.rd = m.writes_rd ? rd : 5'd0;
        return m;
    endfunction

endpackage

// File: rtl/pipeline_stage_meta.sv
// Metadata shift register for pipeline stages 1..NUM_STAGES-1. Stage 1 loads the
// fetch entry, stage 2 loads the decoded entry, older stages shift; clear beats advance.
module pipeline_stage_meta
    import pipeline_hazard_control_pkg::*;
#(
    parameter int NUM_STAGES = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  stage_meta_t           head_in,
    input  stage_meta_t           decode_in,
    input  logic [NUM_STAGES-1:1] advance,
    input  logic [NUM_STAGES-1:1] clear,
    output stage_meta_t           meta [1:NUM_STAGES-1]
);

    stage_meta_t src_s [1:NUM_STAGES-1];

    // source entry each stage would load on advance
    always_comb begin
        src_s[1] = head_in;
        src_s[2] = decode_in;
        for (int s = 3; s < NUM_STAGES; s++) begin
            src_s[s] = meta[s-1];
        end
    end

    // per-stage load / clear / hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 1; s < NUM_STAGES; s++) begin
                meta[s] <= META_EMPTY;
            end
        end else begin
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (clear[s]) begin
                    meta[s] <= META_EMPTY;
                end else if (advance[s]) begin
                    meta[s] <= src_s[s];
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Hazard controller for the SiMPLE pipeline: memory-wait stall, control-transfer flush,
// RAW interlock. Define FORWARDING_EN for a load-use-only interlock (bypass network present).
module pipeline_hazard_control
    import pipeline_hazard_control_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inst_available,
    input  logic                  data_available,
    input  logic [6:0]            id_opcode,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            id_rd,
    input  logic                  take_branch,
    output logic                  pc_write_enable,
    output logic [1:0]            next_pc_select,
    output logic [NUM_STAGES-1:0] stage_advance,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  flush,
    output logic                  load_use_stall,
    output logic                  mem_stall,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int MEM_STAGE = NUM_STAGES - 2;
    localparam int WB_STAGE  = NUM_STAGES - 1;
    localparam logic [NUM_STAGES-1:1] FLUSH_MASK =
        (NUM_STAGES-1)'((64'd1 << BRANCH_STAGE) - 64'd1);

    stage_meta_t           meta_s [1:NUM_STAGES-1];
    stage_meta_t           head_s;
    stage_meta_t           decode_s;
    logic                  mem_wait_s;
    logic                  cti_take_s;
    logic                  raw_hit_s;
    logic [NUM_STAGES-1:1] adv_s;
    logic [NUM_STAGES-1:1] clr_s;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]      flush_cnt_r;

    // fetch entry carries only validity; decode fills the rest when it leaves stage 1
    always_comb begin
        head_s       = META_EMPTY;
        head_s.valid = inst_available;
        decode_s     = decode_meta(meta_s[1].valid, id_opcode, id_rd);
    end

    pipeline_stage_meta #(
        .NUM_STAGES(NUM_STAGES)
    ) u_meta (
        .clock    (clock),
        .reset_n  (reset_n),
        .head_in  (head_s),
        .decode_in(decode_s),
        .advance  (adv_s),
        .clear    (clr_s),
        .meta     (meta_s)
    );

    // raw hazard conditions before priority resolution
    always_comb begin
        mem_wait_s = meta_s[MEM_STAGE].valid & meta_s[MEM_STAGE].is_mem & ~data_available;
        case (meta_s[BRANCH_STAGE].cti)
            CTI_JAL, CTI_JALR: cti_take_s = meta_s[BRANCH_STAGE].valid;
            CTI_BRANCH:        cti_take_s = meta_s[BRANCH_STAGE].valid & take_branch;
            default:           cti_take_s = 1'b0;
        endcase
        raw_hit_s = 1'b0;
`ifdef FORWARDING_EN
        raw_hit_s = meta_s[2].valid & meta_s[2].is_load & (meta_s[2].rd != 5'd0) &
                    ((meta_s[2].rd == id_rs1) | (meta_s[2].rd == id_rs2));
`else
        for (int s = 2; s < NUM_STAGES; s++) begin
            raw_hit_s = raw_hit_s | (meta_s[s].valid & meta_s[s].writes_rd &
                        (meta_s[s].rd != 5'd0) &
                        ((meta_s[s].rd == id_rs1) | (meta_s[s].rd == id_rs2)));
        end
`endif
        raw_hit_s = raw_hit_s & meta_s[1].valid;
    end

    // priority: memory wait, then flush, then RAW interlock, else normal flow / fetch bubble
    always_comb begin
        adv_s           = {(NUM_STAGES-1){1'b1}};
        clr_s           = {(NUM_STAGES-1){1'b0}};
        pc_write_enable = inst_available;
        next_pc_select  = CTL_PC_PC4;
        flush           = 1'b0;
        load_use_stall  = 1'b0;
        mem_stall       = 1'b0;
        if (mem_wait_s) begin
            mem_stall       = 1'b1;
            adv_s           = {(NUM_STAGES-1){1'b0}};
            clr_s[WB_STAGE] = 1'b1;
            pc_write_enable = 1'b0;
        end else if (cti_take_s) begin
            flush           = 1'b1;
            clr_s           = FLUSH_MASK;
            pc_write_enable = 1'b1;
            next_pc_select  = (meta_s[BRANCH_STAGE].cti == CTI_JALR) ? CTL_PC_RS1_IMM
                                                                     : CTL_PC_PC_IMM;
        end else if (raw_hit_s) begin
            load_use_stall  = 1'b1;
            adv_s[1]        = 1'b0;
            clr_s[2]        = 1'b1;
            pc_write_enable = 1'b0;
        end else begin
            pc_write_enable = inst_available;
        end
    end

    // per-stage views exported to the datapath
    always_comb begin
        stage_valid[0] = inst_available;
        for (int s = 1; s < NUM_STAGES; s++) begin
            stage_valid[s] = meta_s[s].valid;
        end
        stage_advance = {adv_s & ~clr_s, pc_write_enable};
    end

    // wrapping stall / flush event counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (mem_stall | load_use_stall) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control: a default 5-stage instance plus a
// 7-stage / BRANCH_STAGE=4 instance driven from the same stimulus.
module tb_pipeline_hazard_control;
    import pipeline_hazard_control_pkg::*;

`ifdef FORWARDING_EN
    localparam int LU_STALLS = 1;
`else
    localparam int LU_STALLS = 3;
`endif

    logic        clock;
    logic        reset_n;
    logic        inst_available;
    logic        data_available;
    logic        take_branch;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        pc_write_enable;
    logic [1:0]  next_pc_select;
    logic [4:0]  stage_advance, stage_valid;
    logic        flush, load_use_stall, mem_stall;
    logic [31:0] stall_count, flush_count;

    logic        pc_we7;
    logic [1:0]  sel7;
    logic [6:0]  adv7, valid7;
    logic        flush7, lus7, ms7;
    logic [31:0] sc7, fc7;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_control dut (
        .clock(clock), .reset_n(reset_n), .inst_available(inst_available),
        .data_available(data_available), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .take_branch(take_branch),
        .pc_write_enable(pc_write_enable), .next_pc_select(next_pc_select),
        .stage_advance(stage_advance), .stage_valid(stage_valid), .flush(flush),
        .load_use_stall(load_use_stall), .mem_stall(mem_stall),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_control #(.NUM_STAGES(7), .BRANCH_STAGE(4), .CNT_W(32)) dut7 (
        .clock(clock), .reset_n(reset_n), .inst_available(inst_available),
        .data_available(data_available), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .take_branch(take_branch),
        .pc_write_enable(pc_we7), .next_pc_select(sel7),
        .stage_advance(adv7), .stage_valid(valid7), .flush(flush7),
        .load_use_stall(lus7), .mem_stall(ms7),
        .stall_count(sc7), .flush_count(fc7)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic avail, input logic dav, input logic tkb,
                         input logic [6:0] opc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        inst_available = avail;
        data_available = dav;
        take_branch    = tkb;
        id_opcode      = opc;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_rd          = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        repeat (5) begin
            drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("drain_empty", stage_valid, 5'b00000);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("rst_valid", stage_valid, 5'b00001);
        check("rst_pc_we", pc_write_enable, 1'b1);
        check("rst_sel", next_pc_select, CTL_PC_PC4);
        check("rst_hazards", {flush, load_use_stall, mem_stall}, 3'b000);
        check("rst_counts", stall_count | flush_count, 32'd0);
        tick();
        reset_n = 1'b1;

        // lw x5 ; add x6,x5,x1
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_LOAD, 5'd1, 5'd0, 5'd5);
        check("lw_no_stall", load_use_stall, 1'b0);
        tick();
        for (int i = 0; i <= LU_STALLS; i++) begin
            drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd5, 5'd1, 5'd6);
            check("lu_stall", load_use_stall, (i < LU_STALLS) ? 1'b1 : 1'b0);
            if (i == 0) begin
                check("lu_advance", stage_advance, 5'b11000);
                check("lu_pc_hold", pc_write_enable, 1'b0);
            end
            tick();
            if (i == 0) begin
                check("lu_bubble", stage_valid, 5'b01011);
            end
            if (i == 1) begin
                check("first_wb", stage_valid[4], 1'b1);
            end
        end
        check("lu_count", stall_count, LU_STALLS);
        drain();

        // taken BEQ at stage 2
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_BRANCH, 5'd1, 5'd2, 5'd3);
        check("beq_decode_noflush", flush, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, OPC_OP, 5'd0, 5'd0, 5'd7);
        check("beq_flush", flush, 1'b1);
        check("beq_sel", next_pc_select, CTL_PC_PC_IMM);
        check("beq_pc_we", pc_write_enable, 1'b1);
        check("beq_valid_pre", stage_valid, 5'b00111);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("beq_squash", stage_valid, 5'b01001);
        check("beq_fcount", flush_count, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_BRANCH, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("bne_noflush", flush, 1'b0);
        check("bne_sel", next_pc_select, CTL_PC_PC4);
        check("fetch_bubble_pc", pc_write_enable, 1'b0);
        tick();
        check("bne_fcount", flush_count, 32'd1);
        drain();

        // JALR with a dependent instruction in decode
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_JALR, 5'd2, 5'd0, 5'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd1, 5'd0, 5'd3);
        check("jalr_flush", flush, 1'b1);
        check("jalr_sel", next_pc_select, CTL_PC_RS1_IMM);
        check("jalr_no_lu", load_use_stall, 1'b0);
        tick();
        check("jalr_scount", stall_count, LU_STALLS);
        check("jalr_fcount", flush_count, 32'd2);
        drain();

        // load waits 3 cycles in memory stage
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_LOAD, 5'd2, 5'd0, 5'd8);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("mem_pre", mem_stall, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
            check("mem_stall", mem_stall, 1'b1);
            check("mem_pc_hold", pc_write_enable, 1'b0);
            tick();
            check("mem_wb_bubble", stage_valid[4], 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("mem_release", mem_stall, 1'b0);
        check("mem_scount", stall_count, LU_STALLS + 3);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("mem_to_wb", stage_valid, 5'b10000);
        drain();

        // JAL waits behind a memory stall
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_LOAD, 5'd0, 5'd0, 5'd9);
        tick();
        drive(1'b0, 1'b1, 1'b0, OPC_JAL, 5'd0, 5'd0, 5'd1);
        check("jal_decode_noflush", flush, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
            check("jal_mem_stall", mem_stall, 1'b1);
            check("jal_deferred", flush, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("jal_flush", flush, 1'b1);
        check("jal_sel", next_pc_select, CTL_PC_PC_IMM);
        tick();
        check("jal_fcount", flush_count, 32'd3);
        check("jal_scount", stall_count, LU_STALLS + 5);

        // fill, then reset mid-stream
        repeat (6) begin
            drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("fill_valid", stage_valid, 5'b11111);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", stage_valid, 5'b00001);
        check("midrst_scount", stall_count, 32'd0);
        check("midrst_fcount", flush_count, 32'd0);
        check("midrst_valid7", valid7, 7'b0000001);
        tick();
        reset_n = 1'b1;

        // 7-stage instance: JAL resolves at stage 4
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_JAL, 5'd0, 5'd0, 5'd0);
        tick();
        repeat (2) begin
            drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
            check("s7_no_early_flush", flush7, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("s7_flush", flush7, 1'b1);
        check("s7_valid_pre", valid7, 7'b0011111);
        tick();
        drive(1'b1, 1'b1, 1'b0, OPC_OP, 5'd0, 5'd0, 5'd0);
        check("s7_squash", valid7, 7'b0100001);
        check("s7_fcount", fc7, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
